// File: rtl/uart_word_assembler.sv
// uart_word_assembler: packs LSB-first UART bits into little-endian words with end-of-message flush; `UART_WORD_OVF_EN` compiles in overflow detection.
module uart_word_assembler #(
  parameter int WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           bit_ready,
  input  logic                           data_in,
  input  logic                           eot,
  output logic [WIDTH-1:0]               word_out,
  output logic [$clog2(WIDTH/8):0]       word_bytes,
  output logic                           word_valid,
  input  logic                           word_ready,
  output logic                           msg_done,
  output logic                           overflow
);
  localparam int NB = WIDTH / 8;
  localparam int IW = $clog2(NB);
  localparam int BW = IW + 1;
  typedef enum logic [1:0] {COLLECT, FLUSH, DONE} state_t;
  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        byte_sr_q, byte_sr_d;
  logic              pend_q, pend_d;
  logic [7:0]        pend_byte_q, pend_byte_d;
  logic [WIDTH-1:0]  word_r_q, word_r_d, word_n;
  logic [IW-1:0]     byte_idx_q, byte_idx_d;
  logic [WIDTH-1:0]  word_out_q, word_out_d;
  logic [BW-1:0]     word_bytes_q, word_bytes_d;
  logic              word_valid_q, word_valid_d;
  logic              free, flush, last_byte;
  assign free      = !word_valid_q || word_ready;
  assign last_byte = byte_idx_q == IW'(NB - 1);
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    byte_sr_d    = byte_sr_q;
    pend_d       = pend_q;
    pend_byte_d  = pend_byte_q;
    word_r_d     = word_r_q;
    byte_idx_d   = byte_idx_q;
    word_out_d   = word_out_q;
    word_bytes_d = word_bytes_q;
    word_valid_d = word_valid_q && !word_ready;
    flush        = 1'b0;
    word_n       = word_r_q;
    word_n[8*byte_idx_q +: 8] = pend_byte_q;
    case (state_q)
      COLLECT: begin
        if (eot) begin
          pend_d    = 1'b0;
          bit_cnt_d = '0;
          state_d   = (byte_idx_q != '0) ? FLUSH : DONE;
          flush     = (byte_idx_q != '0) && free;
        end else if (bit_ready) begin
          byte_sr_d = {data_in, byte_sr_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (pend_q) begin
            pend_d     = 1'b0;
            word_r_d   = last_byte ? '0 : word_n;
            byte_idx_d = last_byte ? '0 : byte_idx_q + 1'b1;
            if (last_byte && free) begin
              word_out_d   = word_n;
              word_bytes_d = BW'(NB);
              word_valid_d = 1'b1;
            end
          end
          if (bit_cnt_q == 3'd7) begin
            pend_d      = 1'b1;
            pend_byte_d = byte_sr_d;
          end
        end
      end
      // a flush loaded on the eot cycle leaves byte_idx at 0, so FLUSH only lingers while blocked
      FLUSH: begin
        state_d = (byte_idx_q == '0) ? DONE : FLUSH;
        flush   = (byte_idx_q != '0) && free;
      end
      default: state_d = COLLECT;
    endcase
    if (flush) begin
      word_out_d   = word_r_q;
      word_bytes_d = BW'(byte_idx_q);
      word_valid_d = 1'b1;
      word_r_d     = '0;
      byte_idx_d   = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= COLLECT;
      bit_cnt_q    <= '0;
      byte_sr_q    <= '0;
      pend_q       <= 1'b0;
      pend_byte_q  <= '0;
      word_r_q     <= '0;
      byte_idx_q   <= '0;
      word_out_q   <= '0;
      word_bytes_q <= '0;
      word_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_sr_q    <= byte_sr_d;
      pend_q       <= pend_d;
      pend_byte_q  <= pend_byte_d;
      word_r_q     <= word_r_d;
      byte_idx_q   <= byte_idx_d;
      word_out_q   <= word_out_d;
      word_bytes_q <= word_bytes_d;
      word_valid_q <= word_valid_d;
    end
  end
  assign word_out   = word_out_q;
  assign word_bytes = word_bytes_q;
  assign word_valid = word_valid_q;
  assign msg_done   = state_q == DONE;
`ifdef UART_WORD_OVF_EN
  logic overflow_q, drop, stray;
  assign drop  = state_q == COLLECT && !eot && bit_ready && pend_q && last_byte && !free;
  assign stray = state_q != COLLECT && (bit_ready || eot);
  always_ff @(posedge clk) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_q || drop || stray;
  end
  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_uart_word_assembler.sv
// tb_uart_word_assembler: directed scenarios with a queue of expected words checked at each handshake.
module tb_uart_word_assembler;
`ifdef UART_WORD_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst, bit_ready, data_in, eot, word_ready;
  logic [31:0] word_out;
  logic [2:0]  word_bytes;
  logic        word_valid, msg_done, overflow;
  int          checks = 0, failures = 0, done_cnt = 0;
  typedef struct {logic [31:0] w; logic [2:0] b;} exp_t;
  exp_t        q[$];

  uart_word_assembler #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .bit_ready(bit_ready), .data_in(data_in), .eot(eot),
    .word_out(word_out), .word_bytes(word_bytes), .word_valid(word_valid),
    .word_ready(word_ready), .msg_done(msg_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] c, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bit_ready = 1'b1;
      data_in   = c[i];
      tick();
      bit_ready = 1'b0;
      repeat (159) tick();
    end
  endtask

  task automatic send_char(input logic [7:0] c);
    send_bits(c, 0, 7);
  endtask

  task automatic push(input logic [31:0] w, input logic [2:0] b);
    exp_t e;
    e.w = w;
    e.b = b;
    q.push_back(e);
  endtask

  task automatic pulse_eot();
    eot = 1'b1;
    tick();
    eot = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (msg_done) done_cnt++;
      if (word_valid && word_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL unexpected_word observed=%0h expected=none", word_out);
        end else begin
          e = q.pop_front();
          check("word_out", word_out, e.w);
          check("word_bytes", word_bytes, e.b);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; bit_ready = 1'b0; data_in = 1'b0; eot = 1'b0; word_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid", word_valid, 0);
    check("rst_word", word_out, 0);
    check("rst_bytes", word_bytes, 0);
    check("rst_done", msg_done, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    repeat (4) tick();
    // three chars, partial flush
    push(32'h009A9A9A, 3);
    repeat (3) send_char(8'h9A);
    send_char(8'h04);
    pulse_eot();
    check("t1_flush_valid", word_valid, 1);
    check("t1_done_early", msg_done, 0);
    tick();
    check("t1_done", msg_done, 1);
    check("t1_ovf", overflow, 0);
    repeat (4) tick();
    // four chars, full word on EOT's first bit
    push(32'h9B9B9B9B, 4);
    repeat (4) send_char(8'h9B);
    check("t2_not_yet", word_valid, 0);
    bit_ready = 1'b1; data_in = 1'b0;
    tick();
    bit_ready = 1'b0;
    check("t2_full_valid", word_valid, 1);
    repeat (159) tick();
    send_bits(8'h04, 1, 7);
    pulse_eot();
    check("t2_done", msg_done, 1);
    check("t2_no_flush", word_valid, 0);
    repeat (4) tick();
    // lone EOT
    send_char(8'h04);
    pulse_eot();
    check("t4_done", msg_done, 1);
    check("t4_no_word", word_valid, 0);
    tick();
    check("t4_done_once", msg_done, 0);
    check("t4_ovf", overflow, 0);
    repeat (4) tick();
    // blocked consumer: second word dropped
    word_ready = 1'b0;
    push(32'h9A9A9A9A, 4);
    repeat (8) send_char(8'h9A);
    send_char(8'h04);
    pulse_eot();
    check("t3_done", msg_done, 1);
    check("t3_held_valid", word_valid, 1);
    check("t3_held_word", word_out, 32'h9A9A9A9A);
    check("t3_held_bytes", word_bytes, 4);
    check("t3_ovf", overflow, OVF);
    word_ready = 1'b1;
    tick();
    tick();
    check("t3_drained", word_valid, 0);
    repeat (4) tick();
    // reset mid-character
    send_char(8'h9A);
    send_bits(8'h9A, 0, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_word", word_out, 0);
    check("t5_rst_bytes", word_bytes, 0);
    check("t5_rst_ovf", overflow, 0);
    push(32'h00000001, 1);
    send_char(8'h01);
    send_char(8'h04);
    pulse_eot();
    check("t5_flush_valid", word_valid, 1);
    tick();
    check("t5_done", msg_done, 1);
    repeat (4) tick();
    // back-to-back strobes
    push(32'h55555555, 4);
    for (int i = 0; i < 40; i++) begin
      bit_ready = 1'b1;
      data_in   = (i % 2 == 0);
      tick();
      if (i == 31) check("t6_before_33", word_valid, 0);
      if (i == 32) check("t6_after_33", word_valid, 1);
    end
    bit_ready = 1'b0;
    pulse_eot();
    check("t6_done", msg_done, 1);
    repeat (6) tick();
    check("sb_drain", q.size(), 0);
    check("msg_done_count", done_cnt, 6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
